// File: rtl/core_pkg.sv
// Shared core constants and the write-back request record.
package core_pkg;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/core_reg_wb_arb_if.sv
// Requester bundle and register-file write port of the write-back arbiter.
interface core_reg_wb_arb_if #(
    parameter int NREQ = 3,
    parameter int XLEN = core_pkg::XLEN,
    parameter int AW   = core_pkg::AW
);
    logic [NREQ-1:0]      REQ_VALID;
    logic [NREQ-1:0]      REQ_READY;
    logic [NREQ*AW-1:0]   REQ_ADDR;
    logic [NREQ*XLEN-1:0] REQ_DATA;
    logic                 HOLD;
    logic                 WE;
    logic [AW-1:0]        WADDR;
    logic [XLEN-1:0]      WDATA;
    logic [31:0]          BUSY;

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_DATA, HOLD,
        input  REQ_READY, WE, WADDR, WDATA, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_DATA, HOLD,
        output REQ_READY, WE, WADDR, WDATA, BUSY
    );
endinterface

// File: rtl/core_rr_arb.sv
// Combinational round-robin arbiter: first requester after i_last wins.
module core_rr_arb #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    logic          w_found;
    logic [IW-1:0] w_pos;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        // Scan last+1 .. last+N so the previous winner has lowest priority.
        for (int k = 1; k <= N; k++) begin
            w_pos = IW'((int'(i_last) + k) % N);
            if (i_en && !w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end
endmodule

// File: rtl/core_reg_wb_arb.sv
// Write-back arbiter for the single register-file write port with
// delayed-commit timing and per-register pending-write tracking.
module core_reg_wb_arb #(
    parameter int NREQ = 3,
    parameter int XLEN = core_pkg::XLEN,
    parameter int AW   = core_pkg::AW
) (
    input logic               CLK,
    input logic               RST_N,
    core_reg_wb_arb_if.slave  bus
);
    localparam int IW    = $clog2(NREQ);
    localparam int NREGS = core_pkg::NREGS;

    logic [NREQ-1:0]    w_gnt;
    logic [IW-1:0]      w_idx;
    logic               w_xfer;
    core_pkg::wb_req_t  w_req;
    logic [NREGS-1:0]   w_set;
    logic [NREGS-1:0]   w_clr;
    logic [NREGS-1:0]   w_busy;

    logic [IW-1:0]      r_last;
    logic               r_a_we;
    core_pkg::wb_req_t  r_a;
    logic               r_b_we;
    logic [AW-1:0]      r_waddr;
    logic [XLEN-1:0]    r_wdata;
    logic [1:0]         r_cnt [NREGS];

    core_rr_arb #(.N(NREQ), .IW(IW)) u_arb (
        .i_req  (bus.REQ_VALID),
        .i_last (r_last),
        .i_en   (!bus.HOLD),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

    assign w_xfer        = |w_gnt;
    assign w_req.addr    = bus.REQ_ADDR[w_idx*AW +: AW];
    assign w_req.data    = bus.REQ_DATA[w_idx*XLEN +: XLEN];
    assign bus.REQ_READY = w_gnt;
    assign bus.WE        = r_a_we;
    assign bus.WADDR     = r_waddr;
    assign bus.WDATA     = r_wdata;
    assign bus.BUSY      = w_busy;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_xfer && (w_req.addr != '0)) w_set[w_req.addr] = 1'b1;
        if (r_b_we)                       w_clr[r_waddr]    = 1'b1;
    end

    always_comb begin
        w_busy = '0;
        for (int r = 1; r < NREGS; r++) w_busy[r] = (r_cnt[r] != 2'd0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last  <= IW'(NREQ - 1);
            r_a_we  <= 1'b0;
            r_a     <= '0;
            r_b_we  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_cnt   <= '{default: 2'd0};
        end else begin
            if (w_xfer) begin
                r_last <= w_idx;
                r_a    <= w_req;
            end
            // Stage A: accept; x0 writes are consumed without a write enable.
            r_a_we <= w_xfer && (w_req.addr != '0);
            // Stage B: address/data follow their WE by one cycle.
            r_b_we <= r_a_we;
            if (r_a_we) begin
                r_waddr <= r_a.addr;
                r_wdata <= r_a.data;
            end
            // Simultaneous set and clear nets out so the register stays busy.
            for (int r = 0; r < NREGS; r++)
                r_cnt[r] <= r_cnt[r] + {1'b0, w_set[r]} - {1'b0, w_clr[r]};
        end
    end
endmodule
